// File: rtl/div_pkg.sv
// Shared types and defaults for the divider issue path.
package div_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_DEPTH = 4;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] dividend;
        logic [DIV_WIDTH-1:0] divisor;
    } div_op_t;

endpackage

// File: rtl/div_op_fifo.sv
// Synchronous operand FIFO; head entry is visible combinationally from storage.
module div_op_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = DIV_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  div_op_t       i_data,
    input  logic          i_pop,
    output div_op_t       o_head,
    output logic [CW-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);

    div_op_t         r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/div_feeder.sv
// Issue stage for the combinational divider: operand FIFO, result slot and
// saturating divide-by-zero counter.
module div_feeder
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DEPTH = DIV_DEPTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic [WIDTH-1:0] div_in1,
    output logic [WIDTH-1:0] div_in2,
    input  logic [WIDTH-1:0] div_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_quot,
    output logic             res_dbz,
    output logic [CNT_W-1:0] dbz_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    div_op_t          w_in_op;
    div_op_t          w_head;
    logic [CW-1:0]    w_count;
    logic             w_push;
    logic             w_pop;
    logic             w_slot_free;
    logic             w_head_dbz;

    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_quot;
    logic             r_res_dbz;
    logic [CNT_W-1:0] r_dbz_count;

    assign w_in_op.dividend = in_dividend;
    assign w_in_op.divisor  = in_divisor;

    // Readiness looks at occupancy only, so a full FIFO refuses even while popping.
    assign in_ready    = rst_n && (w_count < FULL);
    assign w_push      = in_valid && in_ready;
    assign w_slot_free = !r_res_valid || res_ready;
    assign w_pop       = (w_count != '0) && w_slot_free;

    div_op_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_in_op),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign div_in1    = (w_count != '0) ? w_head.dividend : '0;
    assign div_in2    = (w_count != '0) ? w_head.divisor  : '0;
    assign w_head_dbz = (w_head.divisor == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_quot  <= '0;
            r_res_dbz   <= 1'b0;
            r_dbz_count <= '0;
        end else if (w_pop) begin
            r_res_valid <= 1'b1;
            r_res_dbz   <= w_head_dbz;
            // The divider's own zero-divisor output is ignored; force a clean zero.
            r_res_quot  <= w_head_dbz ? '0 : div_out;
            if (w_head_dbz && (r_dbz_count != '1)) begin
                r_dbz_count <= r_dbz_count + CNT_W'(1);
            end
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_quot  = r_res_quot;
    assign res_dbz   = r_res_dbz;
    assign dbz_count = r_dbz_count;

endmodule

// File: tb/tb_div_feeder.sv
// Directed bench for div_feeder with a behavioural divider beside it.
module tb_div_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_dividend;
    logic [7:0] in_divisor;
    logic [7:0] div_in1;
    logic [7:0] div_in2;
    logic [7:0] div_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_quot;
    logic       res_dbz;
    logic [7:0] dbz_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Divider model returns all-ones on zero divisor so a leaked value shows up.
    assign div_out = (div_in2 == 8'd0) ? 8'hFF : div_in1 / div_in2;

    div_feeder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .div_in1     (div_in1),
        .div_in2     (div_in2),
        .div_out     (div_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_quot    (res_quot),
        .res_dbz     (res_dbz),
        .dbz_count   (dbz_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0; res_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (res_valid !== 1'b0 || res_quot !== 8'd0 || res_dbz !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: got v=%0b q=%0d z=%0b, want 0 0 0", res_valid, res_quot, res_dbz);
        end
        checks++;
        if (dbz_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_dbz_count: got %0d, want 0", dbz_count);
        end
        checks++;
        if (in_ready !== 1'b1 || div_in1 !== 8'd0 || div_in2 !== 8'd0) begin
            errors++;
            $display("FAIL reset_idle: got rdy=%0b in1=%0d in2=%0d, want 1 0 0", in_ready, div_in1, div_in2);
        end
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        in_valid = 1'b1; in_dividend = 8'd100; in_divisor = 8'd7;
        tick();
        in_valid = 1'b0;
        checks++;
        if (div_in1 !== 8'd100 || div_in2 !== 8'd7 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_operands: got in1=%0d in2=%0d v=%0b, want 100 7 0", div_in1, div_in2, res_valid);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_quot !== 8'd14 || res_dbz !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got v=%0b q=%0d z=%0b, want 1 14 0", res_valid, res_quot, res_dbz);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0 || res_quot !== 8'd14) begin
            errors++;
            $display("FAIL single_drain: got v=%0b q=%0d, want 0 14", res_valid, res_quot);
        end
    endtask

    task automatic test_dbz();
        res_ready = 1'b1;
        in_valid = 1'b1; in_dividend = 8'd5; in_divisor = 8'd0;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_quot !== 8'd0 || res_dbz !== 1'b1 || dbz_count !== 8'd1) begin
            errors++;
            $display("FAIL dbz_5_0: got v=%0b q=%0d z=%0b cnt=%0d, want 1 0 1 1", res_valid, res_quot, res_dbz, dbz_count);
        end
        in_valid = 1'b1; in_dividend = 8'd0; in_divisor = 8'd3;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_quot !== 8'd0 || res_dbz !== 1'b0 || dbz_count !== 8'd1) begin
            errors++;
            $display("FAIL dbz_0_3: got v=%0b q=%0d z=%0b cnt=%0d, want 1 0 0 1", res_valid, res_quot, res_dbz, dbz_count);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] a_tab [6];
        logic [7:0] b_tab [6];
        logic [7:0] q_tab [6];
        int  idx;
        bit  sixth_taken;
        a_tab = '{8'd200, 8'd9, 8'd7, 8'd3, 8'd255, 8'd1};
        b_tab = '{8'd10,  8'd3, 8'd7, 8'd9, 8'd1,   8'd1};
        q_tab = '{8'd20,  8'd3, 8'd1, 8'd0, 8'd255, 8'd1};
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_dividend = a_tab[i]; in_divisor = b_tab[i];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_ready_pair%0d: got %0b, want 1", i, in_ready);
            end
            tick();
        end
        in_dividend = a_tab[5]; in_divisor = b_tab[5];
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: got in_ready=%0b, want 0", in_ready);
        end
        tick(); tick();
        checks++;
        if (res_valid !== 1'b1 || res_quot !== 8'd20 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got v=%0b q=%0d rdy=%0b, want 1 20 0", res_valid, res_quot, in_ready);
        end
        res_ready = 1'b1;
        idx = 0;
        sixth_taken = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bit accept;
            accept = in_valid && in_ready;
            if (res_valid) begin
                checks++;
                if (idx >= 6 || res_quot !== q_tab[idx]) begin
                    errors++;
                    $display("FAIL bp_order_%0d: got %0d, want %0d", idx, res_quot, (idx < 6) ? q_tab[idx] : 8'hxx);
                end
                idx++;
            end
            tick();
            if (accept) begin
                sixth_taken = 1'b1;
                in_valid = 1'b0;
            end
        end
        checks++;
        if (idx != 6 || !sixth_taken) begin
            errors++;
            $display("FAIL bp_count: got %0d results sixth=%0b, want 6 1", idx, sixth_taken);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] qe [$];
        logic       ze [$];
        int first_c, last_c, got;
        res_ready = 1'b1;
        first_c = -1; last_c = -1; got = 0;
        for (int c = 0; c < 22; c++) begin
            if (c < 16) begin
                logic [7:0] a, b;
                a = 8'($urandom_range(0, 255));
                b = (c == 5) ? 8'd0 : 8'($urandom_range(0, 40));
                in_valid = 1'b1; in_dividend = a; in_divisor = b;
                qe.push_back((b == 8'd0) ? 8'd0 : a / b);
                ze.push_back(b == 8'd0);
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready_%0d: got %0b, want 1", c, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            if (res_valid) begin
                logic [7:0] eq;
                logic       ez;
                eq = qe.pop_front();
                ez = ze.pop_front();
                checks++;
                if (res_quot !== eq || res_dbz !== ez) begin
                    errors++;
                    $display("FAIL stream_result_%0d: got q=%0d z=%0b, want q=%0d z=%0b", got, res_quot, res_dbz, eq, ez);
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (got != 16 || (last_c - first_c) != 15) begin
            errors++;
            $display("FAIL stream_rate: got %0d results over %0d cycles, want 16 over 16", got, last_c - first_c + 1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_dividend = 8'd40 + 8'(i); in_divisor = (i == 0) ? 8'd0 : 8'd2;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || dbz_count !== 8'd1) begin
            errors++;
            $display("FAIL mid_setup: got v=%0b cnt=%0d, want 1 1", res_valid, dbz_count);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (res_valid !== 1'b0 || dbz_count !== 8'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%0b cnt=%0d rdy=%0b, want 0 0 0", res_valid, dbz_count, in_ready);
        end
        rst_n = 1'b1;
        res_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || div_in1 !== 8'd0) begin
            errors++;
            $display("FAIL mid_release: got rdy=%0b in1=%0d, want 1 0", in_ready, div_in1);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale_%0d: got res_valid=%0b, want 0", c, res_valid);
            end
        end
    endtask

    task automatic test_saturation();
        int seen;
        do_reset();
        res_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 264; c++) begin
            in_valid = (c < 260); in_dividend = 8'(c); in_divisor = 8'd0;
            if (res_valid && res_dbz) begin
                seen++;
                if (seen == 200) begin
                    checks++;
                    if (dbz_count !== 8'd200) begin
                        errors++;
                        $display("FAIL sat_mid: got %0d, want 200", dbz_count);
                    end
                end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (dbz_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: got %0d, want 255", dbz_count);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0; res_ready = 1'b0;
        test_reset();
        test_single();
        test_dbz();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
